// File: rtl/johnson_seq_gen.sv
// Johnson / ring sequence generator with phase decode and wrap pulse.
// Optional JSEQ_SELF_CORRECT_EN: stepping from an illegal code re-seeds q.
module johnson_seq_gen #(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] q_r, q_nxt, nq;
  logic             wrap_r, wrap_nxt, fix;
  logic             john_ok, ring_ok;
  int               pc, ridx;

  always_comb begin
    pc   = 0;
    ridx = 0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + (q_r[i] ? 1 : 0);
      if (q_r[i]) ridx = i;
    end
    nq      = ~q_r;
    // thermometer: low ones, or their complement once the msb is set
    john_ok = q_r[WIDTH-1] ? ((nq & (nq + ONE)) == '0)
                           : ((q_r & (q_r + ONE)) == '0);
    ring_ok = (q_r & (q_r - ONE)) == '0;
    err     = mode ? ~ring_ok : ~john_ok;
    phase   = '0;
    if (!err) begin
      if (mode)
        phase = PW'(ridx);
      else if (q_r[WIDTH-1])
        phase = PW'(2*WIDTH - pc);
      else
        phase = PW'(pc);
    end
  end

  always_comb begin
    fix = 1'b0;
`ifdef JSEQ_SELF_CORRECT_EN
    fix = err;
`endif
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = load_val;
    end else if (en) begin
      if (fix) begin
        q_nxt = mode ? ONE : '0;
      end else if (mode && q_r == '0) begin
        q_nxt = ONE;
      end else if (mode) begin
        q_nxt    = dir ? {q_r[0], q_r[WIDTH-1:1]}
                       : {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        wrap_nxt = dir ? (q_r == ONE) : (q_r == MSB);
      end else begin
        q_nxt    = dir ? {~q_r[0], q_r[WIDTH-1:1]}
                       : {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
        wrap_nxt = dir ? (q_r == '0) : (q_r == MSB);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign q    = q_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_johnson_seq_gen.sv
// Scoreboard bench for johnson_seq_gen at WIDTH=4.
// Expected codes come from spec tables and an index-based sequence model.
module tb_johnson_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] q;
  logic [2:0] phase;
  logic       wrap, err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] q;
    logic       w;
    logic [2:0] ph;
    logic       er;
  } exp_t;

  exp_t sb[$];

  johnson_seq_gen #(.WIDTH(4), .PW(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val), .q(q), .phase(phase),
    .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] code(input logic m, input int k);
    logic [3:0] t;
    if (m) return 4'b0001 << k;
    if (k < 4) return (4'b0001 << k) - 4'd1;
    t = (4'b0001 << (k - 4)) - 4'd1;
    return ~t;
  endfunction

  function automatic void model_pe(input logic [3:0] v, input logic m,
                                   output logic [2:0] ph, output logic er);
    er = 1'b1;
    ph = '0;
    if (m && v == 4'b0000) er = 1'b0;
    for (int k = 0; k < (m ? 4 : 8); k++)
      if (v == code(m, k)) begin
        er = 1'b0;
        ph = 3'(k);
      end
  endfunction

  task automatic apply(input logic r, e, d, m, l, input logic [3:0] lv,
                       input logic [3:0] eq, input logic ew);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; dir = d; mode = m; load = l; load_val = lv;
    x.q = eq;
    x.w = ew;
    model_pe(eq, m, x.ph, x.er);
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, 1'b0, i[0], 1'b1, 4'b0101, 4'b0000, 1'b0);
      x = sb.pop_front();
      vectors++;
      if ({q, wrap, phase, err} !== {x.q, x.w, x.ph, x.er}) begin
        miscompares++;
        $display("FAIL reset m=%0d: q=%b w=%b ph=%0d e=%b exp q=%b w=%b ph=%0d e=%b",
                 i, q, wrap, phase, err, x.q, x.w, x.ph, x.er);
      end
    end
  endtask

  task automatic test_johnson_fwd();
    exp_t x;
    logic [3:0] t[9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                         4'b1100, 4'b1000, 4'b0000, 4'b0000};
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 9; i++) begin
      apply(1'b0, i < 8, 1'b0, 1'b0, 1'b0, 4'h0, t[i], i == 7);
      x = sb.pop_front();
      vectors++;
      if ({q, wrap, phase, err} !== {x.q, x.w, x.ph, x.er}) begin
        miscompares++;
        $display("FAIL jfwd[%0d]: q=%b w=%b ph=%0d e=%b exp q=%b w=%b ph=%0d e=%b",
                 i, q, wrap, phase, err, x.q, x.w, x.ph, x.er);
      end
    end
  endtask

  task automatic test_johnson_rev();
    exp_t x;
    logic [3:0] t[3] = '{4'b1000, 4'b1000, 4'b1100};
    logic       w[3] = '{1'b1, 1'b0, 1'b0};
    logic       e[3] = '{1'b1, 1'b0, 1'b1};
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, e[i], 1'b1, 1'b0, 1'b0, 4'h0, t[i], w[i]);
      x = sb.pop_front();
      vectors++;
      if ({q, wrap, phase, err} !== {x.q, x.w, x.ph, x.er}) begin
        miscompares++;
        $display("FAIL jrev[%0d]: q=%b w=%b ph=%0d e=%b exp q=%b w=%b ph=%0d e=%b",
                 i, q, wrap, phase, err, x.q, x.w, x.ph, x.er);
      end
    end
  endtask

  task automatic test_ring();
    exp_t x;
    logic [3:0] t[7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                         4'b1000, 4'b0100};
    logic       w[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 1'b1, i >= 5, 1'b1, 1'b0, 4'h0, t[i], w[i]);
      x = sb.pop_front();
      vectors++;
      if ({q, wrap, phase, err} !== {x.q, x.w, x.ph, x.er}) begin
        miscompares++;
        $display("FAIL ring[%0d]: q=%b w=%b ph=%0d e=%b exp q=%b w=%b ph=%0d e=%b",
                 i, q, wrap, phase, err, x.q, x.w, x.ph, x.er);
      end
    end
  endtask

  task automatic test_illegal_load();
    exp_t x;
    logic       m[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       l[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] lv[4] = '{4'b0101, 4'h0, 4'b0110, 4'h0};
`ifdef JSEQ_SELF_CORRECT_EN
    logic [3:0] t[4]  = '{4'b0101, 4'b0000, 4'b0110, 4'b0001};
`else
    logic [3:0] t[4]  = '{4'b0101, 4'b1011, 4'b0110, 4'b1100};
`endif
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 1'b0, m[i], l[i], lv[i], t[i], 1'b0);
      x = sb.pop_front();
      vectors++;
      if ({q, wrap, phase, err} !== {x.q, x.w, x.ph, x.er}) begin
        miscompares++;
        $display("FAIL illegal[%0d]: q=%b w=%b ph=%0d e=%b exp q=%b w=%b ph=%0d e=%b",
                 i, q, wrap, phase, err, x.q, x.w, x.ph, x.er);
      end
    end
  endtask

  task automatic test_load_priority();
    exp_t x;
    logic       r[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       m[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       l[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       e[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] lv[6] = '{4'b0011, 4'h0, 4'h0, 4'b1000, 4'h0, 4'b0111};
    logic [3:0] t[6]  = '{4'b0011, 4'b0011, 4'b0011, 4'b1000, 4'b1000, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      apply(r[i], e[i], 1'b0, m[i], l[i], lv[i], t[i], 1'b0);
      x = sb.pop_front();
      vectors++;
      if ({q, wrap, phase, err} !== {x.q, x.w, x.ph, x.er}) begin
        miscompares++;
        $display("FAIL prio[%0d]: q=%b w=%b ph=%0d e=%b exp q=%b w=%b ph=%0d e=%b",
                 i, q, wrap, phase, err, x.q, x.w, x.ph, x.er);
      end
    end
  endtask

  task automatic test_random();
    exp_t       x;
    logic [3:0] cur, nq, lv;
    logic [2:0] ph;
    logic       er, e, d, l, w;
    int         n, ni;
    for (int b = 0; b < 2; b++) begin
      n = b ? 4 : 8;
      apply(1'b1, 1'b0, 1'b0, b[0], 1'b0, 4'h0, 4'h0, 1'b0);
      void'(sb.pop_front());
      cur = '0;
      for (int i = 0; i < 60; i++) begin
        e  = $urandom_range(0, 3) != 0;
        d  = $urandom_range(0, 1) == 1;
        l  = $urandom_range(0, 9) == 0;
        lv = code(b[0], $urandom_range(0, n - 1));
        model_pe(cur, b[0], ph, er);
        w  = 1'b0;
        nq = cur;
        if (l) begin
          nq = lv;
        end else if (e && b == 1 && cur == 4'b0000) begin
          nq = 4'b0001;
        end else if (e) begin
          ni = d ? (int'(ph) + n - 1) % n : (int'(ph) + 1) % n;
          w  = d ? (ph == 0) : (int'(ph) == n - 1);
          nq = code(b[0], ni);
        end
        apply(1'b0, e, d, b[0], l, lv, nq, w);
        cur = nq;
        x = sb.pop_front();
        vectors++;
        if ({q, wrap, phase, err} !== {x.q, x.w, x.ph, x.er}) begin
          miscompares++;
          $display("FAIL rand[%0d.%0d]: q=%b w=%b ph=%0d e=%b exp q=%b w=%b ph=%0d e=%b",
                   b, i, q, wrap, phase, err, x.q, x.w, x.ph, x.er);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_johnson_fwd();
    test_johnson_rev();
    test_ring();
    test_illegal_load();
    test_load_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/johnson_seq_gen.md
JOHNSON_SEQ_GEN -- requirements
Module: johnson_seq_gen

Interface
REQ-001 Parameter WIDTH, default 8, counter state width; legal range 2..32.
REQ-002 Parameter PW, default $clog2(2*WIDTH), phase output width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-high (rst_n=1 resets); name kept for continuity with existing blocks.
REQ-005 en  input  1  step enable; one step per cycle while high.
REQ-006 dir  input  1  0=forward, 1=reverse.
REQ-007 mode  input  1  0=Johnson (twisted ring), 1=ring (circulating one-hot).
REQ-008 load  input  1  parallel load strobe.
REQ-009 load_val  input  WIDTH  value written to q on load.
REQ-010 q  output  WIDTH  registered counter state.
REQ-011 phase  output  PW  combinational position of q in its sequence.
REQ-012 wrap  output  1  registered one-cycle pulse on sequence wrap.
REQ-013 err  output  1  combinational; q is not a legal code for the current mode.

Function
REQ-014 Priority per cycle SHALL be: rst_n > load > en > hold.
REQ-015 Johnson forward step SHALL be q <= {q[WIDTH-2:0], ~q[WIDTH-1]}; Johnson reverse SHALL be q <= {~q[0], q[WIDTH-1:1]}.
REQ-016 Ring forward step SHALL be q <= {q[WIDTH-2:0], q[WIDTH-1]}; ring reverse SHALL be q <= {q[0], q[WIDTH-1:1]}.
REQ-017 Ring mode with q==0 and en=1 SHALL load q <= 1 (seed) regardless of dir; no wrap.
REQ-018 Johnson legal codes: thermometer patterns only (k low ones, or k high ones after the all-ones state); 2*WIDTH codes.
REQ-019 Ring legal codes: all-zero (idle) or exactly one bit set.
REQ-020 Johnson phase SHALL be popcount(q) if q[WIDTH-1]==0, else 2*WIDTH-popcount(q); range 0..2*WIDTH-1.
REQ-021 Ring phase SHALL be the index of the set bit; 0 when q==0.
REQ-022 err SHALL be 1 and phase SHALL be 0 whenever q is illegal for the current mode.
REQ-023 wrap SHALL assert in the cycle after an en step moves phase from last to 0 (forward) or from 0 to last (reverse); last = 2*WIDTH-1 (Johnson) or WIDTH-1 (ring).
REQ-024 Loads, the ring seed step and reset SHALL never assert wrap; wrap SHALL be 0 in all other cycles.
REQ-025 mode or dir change SHALL take effect at the next step without altering q; err re-evaluates immediately against the new mode.
REQ-026 load_val SHALL be stored unmodified even if illegal; err then reports it.

Reset
REQ-027 On a clock edge with rst_n=1: q=0, wrap=0; hence phase=0 and err=0 in both modes.
REQ-028 Reset mid-sequence SHALL discard any concurrent load or en in that cycle.

Configuration
REQ-029 Macro JSEQ_SELF_CORRECT_EN: when defined, an en step taken from an illegal q SHALL set q to 0 (Johnson) or 1 (ring), with wrap=0.
REQ-030 Without JSEQ_SELF_CORRECT_EN, an illegal q SHALL step per REQ-015/016 unchanged; err remains the only indication.

Verification (WIDTH=4)
REQ-031 Reset, mode=0, dir=0, en=1 for 8 cycles -> q 0001,0011,0111,1111,1110,1100,1000,0000; phase 1..7,0; wrap=1 only after the 8th step.
REQ-032 Reset, mode=0, dir=1, one step -> q=1000, phase=7, wrap=1 for one cycle.
REQ-033 Reset, mode=1, dir=0, en=1 for 5 cycles -> q 0001 (seed, no wrap),0010,0100,1000,0001; wrap=1 only after the last step.
REQ-034 load=1, load_val=0101, mode=0 -> q=0101, err=1, phase=0; next en step dir=0 -> q=0000 with macro, q=1011 without.
REQ-035 load=1 and en=1 together, load_val=0011 -> q=0011 (no step), wrap=0; rst_n=1 with load=1 mid-run -> q=0000.
